sram_write_ctrl: RTL
====================

SRAM_WRITE_CTRL -- requirements
Module: SRAM_WRITE_CTRL

Interface
REQ-001 Parameter ADDR_W, default 18: SRAM address width; capture depth 2^ADDR_W samples.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 nRESET  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  capture start or restart request, sampled high on one CLK edge.
REQ-005 SYNC_EVENT  input  1  trigger qualifier from the sync comparator stage.
REQ-006 PRE_CNT  input  ADDR_W  pre-trigger sample count.
REQ-007 POST_CNT  input  ADDR_W  post-trigger sample count.
REQ-008 SAMPLE_EN  input  1  sample-rate clock enable (decimation strobe).
REQ-009 ADDR_CNT_EN  input  1  per-sample write qualifier from the MIN/MAX/RLE stage (RLE suppress).
REQ-010 DATA_A_IN  input  8  channel A / LA data from the MIN/MAX/RLE stage.
REQ-011 DATA_B_IN  input  8  channel B / RLE code from the MIN/MAX/RLE stage.
REQ-012 SRAM_ADDR  output  ADDR_W  registered SRAM address.
REQ-013 SRAM_DATA_A, SRAM_DATA_B  output  8 each  registered SRAM write data.
REQ-014 SRAM_nWE  output  1  registered active-low write strobe.
REQ-015 TRIG_ADDR  output  ADDR_W  address of the first post-trigger write.
REQ-016 BUSY  output  1  high in PRE, WAIT_TRIG and POST.
REQ-017 DONE  output  1  high in DONE.

Function
REQ-018 States: IDLE, PRE, WAIT_TRIG, POST, DONE; encoding is free.
REQ-019 Write qualifier WQ = SAMPLE_EN & ADDR_CNT_EN & BUSY.
REQ-020 Edge t with WQ=1: during t+1, SRAM_nWE=0, SRAM_DATA_A/B = DATA_A_IN/DATA_B_IN sampled at t, SRAM_ADDR = write pointer at t.
REQ-021 The pointer increments by 1 at edge t+1, modulo 2^ADDR_W (wraps from all-ones to 0).
REQ-022 With WQ=0, SRAM_nWE=1 and SRAM_ADDR/DATA hold their last values.
REQ-023 A write strobe is never longer than one cycle per WQ; back-to-back WQ gives a continuous low strobe with an advancing address.
REQ-024 IDLE or DONE with START=1: pointer, pre counter and post counter cleared. Next state is WAIT_TRIG if PRE_CNT=0, otherwise PRE.
REQ-025 PRE: each WQ increments the pre counter; the write that makes the count equal PRE_CNT moves the block to WAIT_TRIG. SYNC_EVENT is ignored in PRE.
REQ-026 WAIT_TRIG, SYNC_EVENT=1 at edge t:
  - TRIG_ADDR latches the pointer value after any write at t.
  - Next state is POST, or DONE if POST_CNT=0.
  - A WQ coincident with the trigger is written but not counted as post-trigger.
REQ-027 POST: each WQ increments the post counter; the write that makes the count equal POST_CNT moves the block to DONE. SYNC_EVENT is ignored.
REQ-028 START=1 in PRE, WAIT_TRIG or POST restarts per REQ-024; no write is issued for a WQ in that cycle.
REQ-029 DONE holds SRAM_ADDR, TRIG_ADDR and all data until START.
REQ-030 PRE_CNT and POST_CNT are sampled live; the MCU holds them stable while BUSY=1.

Reset
REQ-031 nRESET low, asynchronously:
  - State IDLE.
  - SRAM_nWE=1.
  - SRAM_ADDR, SRAM_DATA_A, SRAM_DATA_B and TRIG_ADDR = 0.
  - BUSY=0, DONE=0.
  - Pointer and counters = 0.
REQ-032 Reset asserted mid-capture aborts the capture with no further strobe. Deassertion is synchronised to CLK; the first active edge is the one after release.

Configuration
REQ-033 Macro SRAM_WRITE_AUTO_TRIG_EN.
REQ-034 Defined:
  - Adds input AUTO_MODE (1 bit).
  - In WAIT_TRIG, the block counts WQ writes.
  - When AUTO_MODE=1 and the count reaches 2^ADDR_W-1 without a SYNC_EVENT, it forces a trigger exactly as REQ-026.
  - The count clears on entry to WAIT_TRIG.
REQ-035 Not defined: no AUTO_MODE port and no auto-trigger logic; WAIT_TRIG exits only on SYNC_EVENT, START or reset.

Verification
REQ-036 ADDR_W=4, PRE_CNT=3, POST_CNT=2, SAMPLE_EN=ADDR_CNT_EN=1, START, SYNC_EVENT at 6th write:
  - strobes at addresses 0-7;
  - TRIG_ADDR=6;
  - DONE after address 7;
  - exactly 8 strobes.
REQ-037 PRE_CNT=0, POST_CNT=0, START then SYNC_EVENT next cycle: WAIT_TRIG directly, DONE one cycle after trigger, TRIG_ADDR equals pointer.
REQ-038 ADDR_W=4, wait 20 writes in WAIT_TRIG: SRAM_ADDR wraps 15 to 0; data A=0x5A at address 15 written exactly once per pass.
REQ-039 ADDR_CNT_EN toggling 1,0,1,0 with SAMPLE_EN=1: strobes only on qualifying cycles, address advances by 1 per strobe only.
REQ-040 nRESET low during POST, then START: SRAM_nWE=1 immediately, all outputs 0; capture restarts at address 0. Separately, START during POST restarts at address 0 with BUSY held high.
REQ-041 Built with SRAM_WRITE_AUTO_TRIG_EN, ADDR_W=4, AUTO_MODE=1, no SYNC_EVENT: forced trigger after 15 WAIT_TRIG writes. Built without the macro: block stays in WAIT_TRIG indefinitely.

Source files
------------

// File: rtl/sram_write_ctrl_if.sv
// Capture-side bus of sram_write_ctrl: sample stream, MCU capture setup and SRAM write port.
// master = MCU / sample-pipeline side, slave = the write controller.
interface sram_write_ctrl_if #(parameter int ADDR_W = 18);
  logic              START;
  logic              SYNC_EVENT;
  logic [ADDR_W-1:0] PRE_CNT;
  logic [ADDR_W-1:0] POST_CNT;
  logic              SAMPLE_EN;
  logic              ADDR_CNT_EN;
  logic [7:0]        DATA_A_IN;
  logic [7:0]        DATA_B_IN;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [7:0]        SRAM_DATA_A;
  logic [7:0]        SRAM_DATA_B;
  logic              SRAM_nWE;
  logic [ADDR_W-1:0] TRIG_ADDR;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, SYNC_EVENT, PRE_CNT, POST_CNT, SAMPLE_EN, ADDR_CNT_EN, DATA_A_IN, DATA_B_IN,
    input  SRAM_ADDR, SRAM_DATA_A, SRAM_DATA_B, SRAM_nWE, TRIG_ADDR, BUSY, DONE
  );
  modport slave (
    input  START, SYNC_EVENT, PRE_CNT, POST_CNT, SAMPLE_EN, ADDR_CNT_EN, DATA_A_IN, DATA_B_IN,
    output SRAM_ADDR, SRAM_DATA_A, SRAM_DATA_B, SRAM_nWE, TRIG_ADDR, BUSY, DONE
  );
endinterface

// File: rtl/sram_write_ctrl.sv
// Pre/post-trigger capture write controller for the sample SRAM (ring buffer, registered strobe).
// Optional SRAM_WRITE_AUTO_TRIG_EN: AUTO_MODE forces a trigger after a full buffer of WAIT_TRIG writes.
module sram_write_ctrl #(
  parameter int ADDR_W = 18
) (
  input  logic CLK,
  input  logic nRESET,
`ifdef SRAM_WRITE_AUTO_TRIG_EN
  input  logic AUTO_MODE,
`endif
  sram_write_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ALL1 = '1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, pre_cnt, post_cnt;
  logic [ADDR_W-1:0] sram_addr, trig_addr;
  logic [7:0]        sram_da, sram_db;
  logic              sram_nwe;
  logic              busy, wq, do_wr, restart, trig, auto_hit;

  assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign wq   = bus.SAMPLE_EN & bus.ADDR_CNT_EN & busy;

`ifdef SRAM_WRITE_AUTO_TRIG_EN
  logic [ADDR_W-1:0] auto_cnt;
  // Counter saturates so a late AUTO_MODE assertion still forces the trigger.
  assign auto_hit = AUTO_MODE && (state == S_WAIT) &&
                    ((auto_cnt == ALL1) || (wq && (auto_cnt == ALL1 - ONE)));

  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET)                                 auto_cnt <= '0;
    else if (state != S_WAIT || restart || trig) auto_cnt <= '0;
    else if (do_wr && auto_cnt != ALL1)          auto_cnt <= auto_cnt + ONE;
`else
  assign auto_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) state <= S_IDLE;
    else         state <= state_n;

  always_comb begin
    state_n = state;
    restart = 1'b0;
    do_wr   = 1'b0;
    trig    = 1'b0;
    if (bus.START) begin
      // Restart from any state; a WQ in this cycle is dropped.
      restart = 1'b1;
      state_n = (bus.PRE_CNT == '0) ? S_WAIT : S_PRE;
    end else begin
      case (state)
        S_PRE: begin
          do_wr = wq;
          if (wq && (pre_cnt + ONE == bus.PRE_CNT)) state_n = S_WAIT;
        end
        S_WAIT: begin
          do_wr = wq;
          if (bus.SYNC_EVENT || auto_hit) begin
            trig    = 1'b1;
            state_n = (bus.POST_CNT == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          do_wr = wq;
          if (wq && (post_cnt + ONE == bus.POST_CNT)) state_n = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      ptr       <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      sram_addr <= '0;
      sram_da   <= '0;
      sram_db   <= '0;
      sram_nwe  <= 1'b1;
      trig_addr <= '0;
    end else begin
      sram_nwe <= ~do_wr;
      if (restart) begin
        ptr      <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
      end else begin
        if (do_wr) begin
          sram_addr <= ptr;
          sram_da   <= bus.DATA_A_IN;
          sram_db   <= bus.DATA_B_IN;
          ptr       <= ptr + ONE;
        end
        if (do_wr && state == S_PRE)  pre_cnt  <= pre_cnt + ONE;
        if (do_wr && state == S_POST) post_cnt <= post_cnt + ONE;
        // A trigger-coincident write lands before TRIG_ADDR, so point past it.
        if (trig) trig_addr <= do_wr ? ptr + ONE : ptr;
      end
    end

  assign bus.SRAM_ADDR   = sram_addr;
  assign bus.SRAM_DATA_A = sram_da;
  assign bus.SRAM_DATA_B = sram_db;
  assign bus.SRAM_nWE    = sram_nwe;
  assign bus.TRIG_ADDR   = trig_addr;
  assign bus.BUSY        = busy;
  assign bus.DONE        = (state == S_DONE);
endmodule
